// File: rtl/regfile_write_arbiter.sv
// Write-back arbiter for the register file's single write port: alternates
// between ALU results and load returns, and holds ALU writes behind outstanding loads.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_alu_valid,
  input  logic [ADDR_W-1:0]       i_alu_addr,
  input  logic [DATA_W-1:0]       i_alu_data,
  output logic                    o_alu_ready,
  input  logic                    i_mem_valid,
  input  logic [ADDR_W-1:0]       i_mem_addr,
  input  logic [DATA_W-1:0]       i_mem_data,
  output logic                    o_mem_ready,
  input  logic                    i_issue_load,
  input  logic [ADDR_W-1:0]       i_issue_addr,
  output logic [(1<<ADDR_W)-1:0]  o_busy,
  output logic                    o_wr_en,
  output logic [ADDR_W-1:0]       o_wr_addr,
  output logic [DATA_W-1:0]       o_wr_data
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } pri_t;

  pri_t                r_ptr;
  pri_t                w_ptr_nxt;
  logic [NREG-1:0]     r_busy;
  logic [NREG-1:0]     w_busy_nxt;
  logic                w_alu_free;
  logic                w_alu_elig;
  logic                w_alu_grant;
  logic                w_mem_grant;
  logic                w_grant_any;
  logic [ADDR_W-1:0]   w_grant_addr;
  logic [DATA_W-1:0]   w_grant_data;
  logic                r_wr_en_p1;
  logic [ADDR_W-1:0]   r_wr_addr_p1;
  logic [DATA_W-1:0]   r_wr_data_p1;

  // Set is applied after clear so a load issued on the cycle its predecessor
  // returns keeps the register marked busy; register 0 never holds a hazard.
  function automatic logic [NREG-1:0] busy_update(
    input logic [NREG-1:0]   cur,
    input logic              clr,
    input logic [ADDR_W-1:0] clr_addr,
    input logic              set,
    input logic [ADDR_W-1:0] set_addr
  );
    logic [NREG-1:0] nxt;
    nxt = cur;
    if (clr) nxt[clr_addr] = 1'b0;
    if (set) nxt[set_addr] = 1'b1;
    nxt[0] = 1'b0;
    return nxt;
  endfunction

  // ---- stage p0: arbitration and scoreboard next-state ----
  assign w_alu_free  = ~r_busy[i_alu_addr];
  assign w_alu_elig  = i_alu_valid & w_alu_free;
  assign o_mem_ready = i_rst_n & ((r_ptr == PRI_MEM) | ~w_alu_elig);
  assign o_alu_ready = i_rst_n & w_alu_free & ((r_ptr == PRI_ALU) | ~i_mem_valid);
  assign w_mem_grant = i_mem_valid & o_mem_ready;
  assign w_alu_grant = i_alu_valid & o_alu_ready;
  assign w_grant_any = w_mem_grant | w_alu_grant;

  always_comb begin
    w_ptr_nxt    = r_ptr;
    w_grant_addr = i_alu_addr;
    w_grant_data = i_alu_data;
    if (w_mem_grant) begin
      w_ptr_nxt    = PRI_ALU;
      w_grant_addr = i_mem_addr;
      w_grant_data = i_mem_data;
    end else if (w_alu_grant) begin
      w_ptr_nxt    = PRI_MEM;
    end
    w_busy_nxt = busy_update(r_busy, w_mem_grant, i_mem_addr, i_issue_load, i_issue_addr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr  <= PRI_MEM;
      r_busy <= '0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // ---- stage p1: registered write port ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
      r_wr_en_p1 <= w_grant_any & (w_grant_addr != '0);
      if (w_grant_any) begin
        r_wr_addr_p1 <= w_grant_addr;
        r_wr_data_p1 <= w_grant_data;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_wr_en   = r_wr_en_p1;
  assign o_wr_addr = r_wr_addr_p1;
  assign o_wr_data = r_wr_data_p1;

endmodule
